uart_receiver_cfg: RTL

UART_RECEIVER_CFG -- requirements
Module: uart_receiver_cfg

---
 rtl/uart_receiver_cfg.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver_cfg.sv
// ---------------------------------------------------------------------------
// uart_receiver_cfg
//    Configurable UART receiver: start bit, DATA_BITS data bits (LSB first),
//    optional even/odd parity bit, one or two stop bits.  Each received frame
//    is reported by a one-cycle o_Rx_DV pulse.  Frames with errors are still
//    delivered, with their status flags.
//
//    Build option:
//       UART_RX_MAJORITY_EN  - when defined, every bit is the 2-of-3 majority
//                              of the samples at centre-1, centre and centre+1.
//                              When undefined, a single centre sample is used.
//
// Parameters
//    CLKS_PER_BIT  clock cycles per bit (8..4095)
//    DATA_BITS     data bits per frame (5..9)
//    PARITY        0 none, 1 even, 2 odd
//    STOP_BITS     1 or 2
//
// Ports
//    i_Clock       sole clock, rising edge
//    i_Rst_n       asynchronous active-low reset
//    i_Rx_Serial   asynchronous serial line, idle high
//    o_Rx_DV       one-cycle pulse, frame received (byte and status valid)
//    o_Rx_Byte     received data, bit 0 = first data bit on the line
//    o_Parity_Err  parity mismatch on the delivered frame (0 when PARITY=0)
//    o_Frame_Err   at least one stop-bit sample was 0
//    o_Break       all data, parity and stop samples were 0
//    o_Busy        receiver is not idle
// ---------------------------------------------------------------------------
module uart_receiver_cfg #(
   parameter int CLKS_PER_BIT = 347,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Rst_n,
   input  logic                 i_Rx_Serial,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Break,
   output logic                 o_Busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = 4;

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_PARITY    = 3'd3;
   localparam logic [2:0] ST_STOP      = 3'd4;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

   logic                 rx_meta;
   logic                 line_s;
   logic                 line_lvl;   // level used for start detection / wait-high
   logic                 rx_bit;     // bit value used at a sample point

   logic [2:0]           state;
   logic [CNT_W-1:0]     clk_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] data_sr;
   logic                 par_acc;
   logic                 par_err;
   logic                 frm_err;
   logic                 seen_one;   // any 1 among data/parity/stop samples

   // -------------------------------------------------------------------------
   // Two-flop synchroniser, reset to the idle (high) line level.
   // -------------------------------------------------------------------------
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         rx_meta <= 1'b1;
         line_s  <= 1'b1;
      end else begin
         rx_meta <= i_Rx_Serial;
         line_s  <= rx_meta;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   // The whole receiver runs one cycle behind line_s so that, at the cycle
   // where the counter hits a centre count, line_d2/line_d1/line_s hold the
   // centre-1/centre/centre+1 samples.  Bit spacing is unaffected.
   logic line_d1;
   logic line_d2;

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         line_d1 <= 1'b1;
         line_d2 <= 1'b1;
      end else begin
         line_d1 <= line_s;
         line_d2 <= line_d1;
      end
   end

   assign line_lvl = line_d1;
   assign rx_bit   = (line_d2 & line_d1) | (line_d2 & line_s) | (line_d1 & line_s);
`else
   assign line_lvl = line_s;
   assign rx_bit   = line_s;
`endif

   assign o_Busy = (state != ST_IDLE);

   // -------------------------------------------------------------------------
   // Receive FSM.  After the start-bit centre the counter is cleared, so every
   // later sample lands at CNT_LAST, one full bit after the previous centre.
   // -------------------------------------------------------------------------
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state        <= ST_IDLE;
         clk_cnt      <= '0;
         bit_cnt      <= '0;
         data_sr      <= '0;
         par_acc      <= 1'b0;
         par_err      <= 1'b0;
         frm_err      <= 1'b0;
         seen_one     <= 1'b0;
         o_Rx_DV      <= 1'b0;
         o_Rx_Byte    <= '0;
         o_Parity_Err <= 1'b0;
         o_Frame_Err  <= 1'b0;
         o_Break      <= 1'b0;
      end else begin
         o_Rx_DV <= 1'b0;

         case (state)
            ST_IDLE: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               if (!line_lvl) begin
                  state <= ST_START;
               end
            end

            ST_START: begin
               if (clk_cnt == CNT_HALF) begin
                  clk_cnt <= '0;
                  if (!rx_bit) begin
                     state    <= ST_DATA;
                     par_acc  <= 1'b0;
                     par_err  <= 1'b0;
                     frm_err  <= 1'b0;
                     seen_one <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            ST_DATA: begin
               if (clk_cnt == CNT_LAST) begin
                  clk_cnt  <= '0;
                  data_sr  <= {rx_bit, data_sr[DATA_BITS-1:1]};
                  par_acc  <= par_acc ^ rx_bit;
                  seen_one <= seen_one | rx_bit;
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            ST_PARITY: begin
               if (clk_cnt == CNT_LAST) begin
                  clk_cnt  <= '0;
                  seen_one <= seen_one | rx_bit;
                  par_err  <= (PARITY == 2) ? ~(par_acc ^ rx_bit) : (par_acc ^ rx_bit);
                  state    <= ST_STOP;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            ST_STOP: begin
               if (clk_cnt == CNT_LAST) begin
                  clk_cnt <= '0;
                  if (bit_cnt == STOP_LAST) begin
                     // Deliver at the last stop centre so a following start
                     // edge half a bit later is not missed.
                     bit_cnt      <= '0;
                     o_Rx_DV      <= 1'b1;
                     o_Rx_Byte    <= data_sr;
                     o_Parity_Err <= par_err;
                     o_Frame_Err  <= frm_err | ~rx_bit;
                     o_Break      <= ~(seen_one | rx_bit);
                     state        <= rx_bit ? ST_IDLE : ST_WAIT_HIGH;
                  end else begin
                     bit_cnt  <= bit_cnt + 1'b1;
                     frm_err  <= frm_err | ~rx_bit;
                     seen_one <= seen_one | rx_bit;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            ST_WAIT_HIGH: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               if (line_lvl) begin
                  state <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
